uart_rx_pkt_ctrl: RTL and testbench
===================================

# uart_rx_pkt_ctrl

Packet-level receive controller that sits directly above the UART receive module. It enables the receiver and consumes its one-cycle byte strobes. It assembles framed packets (header, length, payload, checksum) into an internal payload buffer. Validated packets are presented to the downstream command logic with a valid/ack handshake, and the receiver is throttled while a packet is held.

## Interface

Parameters:
- MAX_LEN, 16: maximum payload bytes per packet (1..255); buffer depth.
- TIMEOUT, 50000: inter-byte timeout in clk cycles, applied once a header has been accepted.
- HDR, 8'hAA: header byte value.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - clk  in  1  system clock; all logic is rising-edge.
  - rst  in  1  asynchronous reset, active-high.
- UART receiver side:
  - rx_en_sig  out  1  receive enable to the UART receiver.
  - rx_done_sig  in  1  one-cycle strobe; rx_data is valid in the same cycle.
  - rx_data  in  8  received byte.
- Downstream packet side:
  - pkt_valid  out  1  a complete, checksum-correct packet is held.
  - pkt_len  out  8  payload length of the held packet.
  - pkt_ack  in  1  downstream releases the held packet.
  - rd_addr  in  $clog2(MAX_LEN)  payload read address.
  - rd_data  out  8  payload byte at rd_addr (combinational read).
- Error reporting:
  - err_pulse  out  1  one-cycle error strobe.
  - err_code  out  2  error cause: 1 = bad length, 2 = bad checksum, 3 = timeout. Holds its value until the next error.

## Operation

- FSM states: HUNT, LEN, DATA, CSUM, HOLD. Reset state is HUNT.
- HUNT:
  - On rx_done_sig with rx_data==HDR, go to LEN.
  - Any other byte is silently dropped and no error is raised.
- LEN:
  - On a byte of 0 or a byte greater than MAX_LEN: raise err 1 and return to HUNT.
  - Otherwise: latch len, set sum=len, set cnt=0, and go to DATA.
- DATA:
  - Each byte is written to buf[cnt], sum=sum+byte (mod 256), and cnt increments.
  - After the byte at cnt==len-1 is written, go to CSUM.
- CSUM:
  - If the byte equals sum: go to HOLD.
  - Otherwise: raise err 2 and return to HUNT.
  - The checksum is the 8-bit sum of the length byte and all payload bytes. Carries are discarded and there is no inversion.
- HOLD:
  - pkt_valid=1, pkt_len=len, and the buffer is frozen.
  - rx_done_sig strobes are ignored; a byte already in flight is dropped.
  - On pkt_ack, go to HUNT.
- Timeout:
  - The counter runs only in LEN, DATA and CSUM. It clears on every rx_done_sig and on every state entry.
  - When it reaches TIMEOUT-1 without a strobe: raise err 3 and return to HUNT.
- rx_data equal to HDR inside a packet is treated as data; there is no resynchronisation mid-packet.
- The buffer is written only in DATA. rd_data is meaningful only while pkt_valid=1. Addresses at or beyond pkt_len return stale contents.

## Timing

- Reset values: rx_en_sig=0, pkt_valid=0, pkt_len=0, err_pulse=0, err_code=0. The FSM is in HUNT, and cnt, sum and the timer are 0. The buffer is not reset.
- rx_en_sig is registered:
  - 1 in every state except HOLD.
  - It rises in the first cycle after rst deasserts.
  - It falls in the same cycle pkt_valid rises, and rises in the same cycle pkt_valid falls.
- Byte strobes: each rx_done_sig is consumed in the cycle it is high. The state and registers update at that clock edge.
- Packet valid timing: pkt_valid rises on the clock edge that samples a correct checksum byte, so it is visible 1 cycle after the strobe.
- Packet release:
  - pkt_valid falls 1 cycle after pkt_ack is sampled high.
  - pkt_ack while pkt_valid=0 is ignored.
  - A pkt_ack held high continuously releases exactly one packet per HOLD entry.
- Errors: err_pulse is high for exactly 1 cycle, registered together with the state change to HUNT. err_code updates in the same cycle.
- Simultaneous events:
  - rx_done_sig in the same cycle the timeout would fire: the byte wins and the timer clears.
  - Error and a new header byte in the same cycle: impossible by construction, since one strobe is handled per cycle.
- Reset mid-packet: everything returns to reset values immediately (asynchronously), and the partial packet is discarded.
- Minimum packet turnaround: 1 cycle in HOLD when pkt_ack is already high at entry.

## Test plan

- Good packet: bytes AA 03 11 22 33 69 -> pkt_valid=1 one cycle after the 69 strobe, pkt_len=3, rd_data at addr 0/1/2 = 11/22/33, rx_en_sig=0. Assert pkt_ack -> pkt_valid=0 and rx_en_sig=1 on the next cycle.
- Hunt and garbage: bytes 55 00 AA 01 7E 7F -> the leading 55 and 00 are dropped, then pkt_len=1 with rd_data[0]=7E; no err_pulse.
- Length errors: AA 00 -> err_pulse with err_code=1, back to HUNT. AA 11 (17 > MAX_LEN=16) -> err_code=1. A following AA 01 05 06 is accepted.
- Checksum error: AA 02 10 20 31 -> err_code=2 and pkt_valid stays 0.
- Timeout: with TIMEOUT=100, send AA 02 10 and then nothing -> err_code=3 exactly 100 cycles after the 10 strobe. A byte arriving in that same cycle prevents the error.
- Backpressure and reset: with pkt_valid held, strobe AA 01 00 01 -> ignored, buffer unchanged. Assert rst mid-payload of the next packet -> all outputs return to reset values; the following good packet is received correctly.

Source files
------------

// File: rtl/uart_rx_pkt_ctrl.sv
// uart_rx_pkt_ctrl: frames UART bytes into checksummed packets and holds them for a downstream consumer
module uart_rx_pkt_ctrl #(
    parameter int         MAX_LEN = 16,
    parameter int         TIMEOUT = 50000,
    parameter logic [7:0] HDR     = 8'hAA
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       rx_en_sig,
    input  logic                       rx_done_sig,
    input  logic [7:0]                 rx_data,
    output logic                       pkt_valid,
    output logic [7:0]                 pkt_len,
    input  logic                       pkt_ack,
    input  logic [$clog2(MAX_LEN)-1:0] rd_addr,
    output logic [7:0]                 rd_data,
    output logic                       err_pulse,
    output logic [1:0]                 err_code
);
    localparam int AW = $clog2(MAX_LEN);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {HUNT, LEN, DATA, CSUM, HOLD} state_t;

    state_t         state, nxt;
    logic [7:0]     len, sum, cnt;
    logic [TW-1:0]  tmr;
    logic [7:0]     mem [MAX_LEN];
    logic           err_n, tmo;
    logic [1:0]     code_n;

    assign tmo     = tmr == TW'(TIMEOUT - 1);
    assign pkt_len = len;
    assign rd_data = mem[rd_addr];

    // next state and error decode; a strobe always takes priority over the timeout
    always_comb begin
        nxt    = state;
        err_n  = 1'b0;
        code_n = 2'd0;
        case (state)
            HUNT: if (rx_done_sig && rx_data == HDR) nxt = LEN;
            LEN: begin
                if (rx_done_sig) begin
                    if (rx_data == 8'd0 || rx_data > 8'(MAX_LEN)) begin
                        nxt    = HUNT;
                        err_n  = 1'b1;
                        code_n = 2'd1;
                    end else begin
                        nxt = DATA;
                    end
                end else if (tmo) begin
                    nxt    = HUNT;
                    err_n  = 1'b1;
                    code_n = 2'd3;
                end
            end
            DATA: begin
                if (rx_done_sig) begin
                    if (cnt == len - 8'd1) nxt = CSUM;
                end else if (tmo) begin
                    nxt    = HUNT;
                    err_n  = 1'b1;
                    code_n = 2'd3;
                end
            end
            CSUM: begin
                if (rx_done_sig) begin
                    if (rx_data == sum) begin
                        nxt = HOLD;
                    end else begin
                        nxt    = HUNT;
                        err_n  = 1'b1;
                        code_n = 2'd2;
                    end
                end else if (tmo) begin
                    nxt    = HUNT;
                    err_n  = 1'b1;
                    code_n = 2'd3;
                end
            end
            HOLD: if (pkt_ack) nxt = HUNT;
            default: nxt = HUNT;
        endcase
    end

    // state, datapath and registered outputs; valid and enable are both derived from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= HUNT;
            len       <= 8'd0;
            sum       <= 8'd0;
            cnt       <= 8'd0;
            tmr       <= '0;
            rx_en_sig <= 1'b0;
            pkt_valid <= 1'b0;
            err_pulse <= 1'b0;
            err_code  <= 2'd0;
        end else begin
            state     <= nxt;
            tmr       <= (nxt != state || rx_done_sig || state == HUNT || state == HOLD) ? '0 : tmr + 1'b1;
            rx_en_sig <= nxt != HOLD;
            pkt_valid <= nxt == HOLD;
            err_pulse <= err_n;
            err_code  <= err_n ? code_n : err_code;
            if (state == LEN && nxt == DATA) begin
                len <= rx_data;
                sum <= rx_data;
                cnt <= 8'd0;
            end else if (state == DATA && rx_done_sig) begin
                sum <= sum + rx_data;
                cnt <= cnt + 8'd1;
            end
        end
    end

    // payload buffer is not reset and is written only while collecting payload
    always_ff @(posedge clk) begin
        if (state == DATA && rx_done_sig) mem[cnt[AW-1:0]] <= rx_data;
    end
endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// tb_uart_rx_pkt_ctrl: directed self-checking bench for the packet receive controller
module tb_uart_rx_pkt_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_en_sig, rx_done_sig = 1'b0;
    logic [7:0] rx_data = 8'd0;
    logic       pkt_valid, pkt_ack = 1'b0;
    logic [7:0] pkt_len, rd_data;
    logic [3:0] rd_addr = 4'd0;
    logic       err_pulse;
    logic [1:0] err_code;
    int         checks = 0;
    int         failures = 0;
    int         err_cnt = 0;

    uart_rx_pkt_ctrl #(.MAX_LEN(16), .TIMEOUT(100), .HDR(8'hAA)) dut (
        .clk(clk), .rst(rst), .rx_en_sig(rx_en_sig), .rx_done_sig(rx_done_sig),
        .rx_data(rx_data), .pkt_valid(pkt_valid), .pkt_len(pkt_len), .pkt_ack(pkt_ack),
        .rd_addr(rd_addr), .rd_data(rd_data), .err_pulse(err_pulse), .err_code(err_code)
    );

    always #5 clk = ~clk;

    // running count of error strobes, sampled mid-cycle
    always @(negedge clk) if (err_pulse) err_cnt++;

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_done_sig = 1'b1;
        rx_data     = b;
        @(negedge clk);
        rx_done_sig = 1'b0;
    endtask

    task automatic ack();
        @(negedge clk);
        pkt_ack = 1'b1;
        @(negedge clk);
        pkt_ack = 1'b0;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_rd(input logic [3:0] a, input logic [7:0] exp);
        rd_addr = a;
        #1;
        checks++;
        if (rd_data !== exp) begin
            failures++;
            $display("FAIL rd_data[%0d]: got %h expected %h", a, rd_data, exp);
        end
    endtask

    task automatic test_reset();
        #1;
        chk("reset rx_en", {7'd0, rx_en_sig}, 8'd0);
        chk("reset pkt_valid", {7'd0, pkt_valid}, 8'd0);
        chk("reset pkt_len", pkt_len, 8'd0);
        chk("reset err_pulse", {7'd0, err_pulse}, 8'd0);
        chk("reset err_code", {6'd0, err_code}, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rx_en after reset", {7'd0, rx_en_sig}, 8'd1);
    endtask

    task automatic test_good_packet();
        send(8'hAA); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
        chk("good pre-csum valid", {7'd0, pkt_valid}, 8'd0);
        send(8'h69);
        chk("good valid", {7'd0, pkt_valid}, 8'd1);
        chk("good len", pkt_len, 8'd3);
        chk("good rx_en low", {7'd0, rx_en_sig}, 8'd0);
        chk_rd(4'd0, 8'h11);
        chk_rd(4'd1, 8'h22);
        chk_rd(4'd2, 8'h33);
        ack();
        chk("good released", {7'd0, pkt_valid}, 8'd0);
        chk("good rx_en back", {7'd0, rx_en_sig}, 8'd1);
    endtask

    task automatic test_hunt();
        int e0;
        e0 = err_cnt;
        send(8'h55); send(8'h00); send(8'hAA); send(8'h01); send(8'h7E); send(8'h7F);
        chk("hunt valid", {7'd0, pkt_valid}, 8'd1);
        chk("hunt len", pkt_len, 8'd1);
        chk_rd(4'd0, 8'h7E);
        chk("hunt no error", 8'(err_cnt - e0), 8'd0);
        ack();
    endtask

    task automatic test_len_errors();
        send(8'hAA); send(8'h00);
        chk("len0 err_pulse", {7'd0, err_pulse}, 8'd1);
        chk("len0 err_code", {6'd0, err_code}, 8'd1);
        @(negedge clk);
        chk("len0 pulse one cycle", {7'd0, err_pulse}, 8'd0);
        send(8'hAA); send(8'h11);
        chk("len17 err_pulse", {7'd0, err_pulse}, 8'd1);
        chk("len17 err_code", {6'd0, err_code}, 8'd1);
        send(8'hAA); send(8'h01); send(8'h05); send(8'h06);
        chk("len recover valid", {7'd0, pkt_valid}, 8'd1);
        chk_rd(4'd0, 8'h05);
        ack();
    endtask

    task automatic test_checksum();
        send(8'hAA); send(8'h02); send(8'h10); send(8'h20); send(8'h31);
        chk("csum err_pulse", {7'd0, err_pulse}, 8'd1);
        chk("csum err_code", {6'd0, err_code}, 8'd2);
        chk("csum no valid", {7'd0, pkt_valid}, 8'd0);
    endtask

    task automatic test_timeout();
        send(8'hAA); send(8'h02); send(8'h10);
        repeat (99) @(negedge clk);
        chk("tmo early", {7'd0, err_pulse}, 8'd0);
        @(negedge clk);
        chk("tmo err_pulse", {7'd0, err_pulse}, 8'd1);
        chk("tmo err_code", {6'd0, err_code}, 8'd3);
        send(8'hAA); send(8'h02); send(8'h10);
        repeat (98) @(negedge clk);
        send(8'h20);
        chk("tmo rescued no pulse", {7'd0, err_pulse}, 8'd0);
        send(8'h32);
        chk("tmo rescued valid", {7'd0, pkt_valid}, 8'd1);
        chk_rd(4'd1, 8'h20);
        ack();
    endtask

    task automatic test_backpressure();
        send(8'hAA); send(8'h02); send(8'hAB); send(8'hCD); send(8'h7A);
        chk("bp valid", {7'd0, pkt_valid}, 8'd1);
        send(8'hAA); send(8'h01); send(8'h00); send(8'h01);
        chk("bp still valid", {7'd0, pkt_valid}, 8'd1);
        chk("bp len kept", pkt_len, 8'd2);
        chk_rd(4'd0, 8'hAB);
        chk_rd(4'd1, 8'hCD);
        ack();
        chk("bp released", {7'd0, pkt_valid}, 8'd0);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        pkt_ack = 1'b1;
        send(8'hAA); send(8'h01); send(8'h42); send(8'h43);
        chk("b2b valid", {7'd0, pkt_valid}, 8'd1);
        @(negedge clk);
        chk("b2b auto release", {7'd0, pkt_valid}, 8'd0);
        chk("b2b rx_en", {7'd0, rx_en_sig}, 8'd1);
        chk_rd(4'd0, 8'h42);
        repeat (3) @(negedge clk);
        chk("b2b stays idle", {7'd0, pkt_valid}, 8'd0);
        pkt_ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        send(8'hAA); send(8'h03); send(8'h01);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid rst rx_en", {7'd0, rx_en_sig}, 8'd0);
        chk("mid rst pkt_len", pkt_len, 8'd0);
        chk("mid rst err_code", {6'd0, err_code}, 8'd0);
        chk("mid rst valid", {7'd0, pkt_valid}, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        send(8'hAA); send(8'h01); send(8'h07); send(8'h08);
        chk("post rst valid", {7'd0, pkt_valid}, 8'd1);
        chk("post rst len", pkt_len, 8'd1);
        chk_rd(4'd0, 8'h07);
        ack();
    endtask

    initial begin
        test_reset();
        test_good_packet();
        test_hunt();
        test_len_errors();
        test_checksum();
        test_timeout();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
